// File: rtl/fetch_pc_unit_pkg.sv
// Shared defines for the fetch PC slice: default vectors, fetch window and next-PC source encoding.
// The optional fetch-address check is enabled by defining FETCH_PC_ADDR_CHK_EN.
package fetch_pc_unit_pkg;

  localparam int unsigned PcWidthDef = 32;
  localparam logic [31:0] ResetVecDef = 32'h0000_3000;
  localparam logic [31:0] ExcVecDef   = 32'h0000_4180;
  localparam logic [31:0] ImemLoDef   = 32'h0000_3000;
  localparam logic [31:0] ImemHiDef   = 32'h0000_6ffc;

  typedef enum logic [2:0] {
    SrcExc,
    SrcEret,
    SrcPend,
    SrcBr,
    SrcSeq
  } pc_src_e;

  // Exception entry and return redirect even while the front end is stalled.
  function automatic logic src_overrides_stall(pc_src_e src);
    return (src == SrcExc) || (src == SrcEret);
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC priority select: exception, eret, pending redirect, branch, sequential.
module fetch_pc_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH   = PcWidthDef,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(ExcVecDef)
) (
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             redir_pend,
  input  logic [WIDTH-1:0] pend_target,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output pc_src_e          src
);

  always_comb begin
    next_pc = pc + WIDTH'(4);
    src     = SrcSeq;
    if (exc_req) begin
      next_pc = EXC_VEC;
      src     = SrcExc;
    end else if (eret_req) begin
      next_pc = epc;
      src     = SrcEret;
    end else if (redir_pend) begin
      next_pc = pend_target;
      src     = SrcPend;
    end else if (br_req) begin
      next_pc = br_target;
      src     = SrcBr;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with stall-buffered branch redirect and exception/eret override.
// Define FETCH_PC_ADDR_CHK_EN to flag misaligned or out-of-window fetch addresses on fetch_exc.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = PcWidthDef,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(ResetVecDef),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(ExcVecDef),
  parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(ImemLoDef),
  parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(ImemHiDef)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic             redir_pend,
  output logic             fetch_exc
);

  // Declaration initialisers give a defined PC before the first clock edge in simulation.
  logic [WIDTH-1:0] pc_q = RESET_VEC;
  logic             redir_pend_q = 1'b0;
  logic [WIDTH-1:0] pend_target_q;

  logic [WIDTH-1:0] pc_d, pend_target_d, next_pc;
  logic             redir_pend_d;
  pc_src_e          src;

  fetch_pc_sel #(
    .WIDTH  (WIDTH),
    .EXC_VEC(EXC_VEC)
  ) u_sel (
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .redir_pend (redir_pend_q),
    .pend_target(pend_target_q),
    .br_req     (br_req),
    .br_target  (br_target),
    .pc         (pc_q),
    .next_pc    (next_pc),
    .src        (src)
  );

  always_comb begin
    pc_d          = pc_q;
    redir_pend_d  = 1'b0;
    pend_target_d = pend_target_q;
    if (src_overrides_stall(src) || !stall) begin
      pc_d = next_pc;
    end
    // While stalled, the latest taken branch wins the buffer; any other case drains or clears it.
    if (!src_overrides_stall(src) && stall) begin
      redir_pend_d = redir_pend_q | br_req;
      if (br_req) begin
        pend_target_d = br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      redir_pend_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_target_q <= pend_target_d;
  end

  assign pc         = pc_q;
  assign redir_pend = redir_pend_q;

  if (IMEM_LO > IMEM_HI) begin : gen_bad_window
    $error("fetch_pc_unit: IMEM_LO must not exceed IMEM_HI");
  end

`ifdef FETCH_PC_ADDR_CHK_EN
  assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
`else
  assign fetch_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; expectations follow FETCH_PC_ADDR_CHK_EN.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        br_req;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        redir_pend;
  logic        fetch_exc;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .br_req    (br_req),
    .br_target (br_target),
    .pc        (pc),
    .redir_pend(redir_pend),
    .fetch_exc (fetch_exc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; br_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] seq [3];
    seq[0] = 32'h3004; seq[1] = 32'h3008; seq[2] = 32'h300c;
    #1;
    checks++;
    if (pc !== 32'h3000) begin
      errors++; $display("FAIL init_pc: got %h want 00003000", pc);
    end
    rst = 1'b1; stall = 1'b1; br_req = 1'b1; br_target = 32'h3400;
    step();
    checks++;
    if (pc !== 32'h3000 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL reset: got pc=%h pend=%b want 00003000/0", pc, redir_pend);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== seq[i]) begin
        errors++; $display("FAIL seq%0d: got %h want %h", i, pc, seq[i]);
      end
    end
  endtask

  task automatic test_pending();
    step();  // 0x300c -> 0x3010
    checks++;
    if (pc !== 32'h3010) begin
      errors++; $display("FAIL pend_setup: got %h want 00003010", pc);
    end
    stall = 1'b1; br_req = 1'b1; br_target = 32'h3400;
    step();
    br_req = 1'b0; br_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pc !== 32'h3010 || redir_pend !== 1'b1) begin
        errors++; $display("FAIL pend_hold%0d: got pc=%h pend=%b want 00003010/1", i, pc,
                           redir_pend);
      end
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h3400 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL pend_release: got pc=%h pend=%b want 00003400/0", pc, redir_pend);
    end
    step();
    checks++;
    if (pc !== 32'h3404) begin
      errors++; $display("FAIL pend_after: got %h want 00003404", pc);
    end
  endtask

  task automatic test_overwrite();
    stall = 1'b1; br_req = 1'b1; br_target = 32'h3500;
    step();
    br_target = 32'h3600;
    step();
    // Release with a fresh branch: the buffered target must win.
    stall = 1'b0; br_target = 32'h3700;
    step();
    checks++;
    if (pc !== 32'h3600 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL overwrite: got pc=%h pend=%b want 00003600/0", pc, redir_pend);
    end
    br_target = 32'h3100;
    step();
    checks++;
    if (pc !== 32'h3100 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL branch: got pc=%h pend=%b want 00003100/0", pc, redir_pend);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h3104) begin
      errors++; $display("FAIL branch_seq: got %h want 00003104", pc);
    end
  endtask

  task automatic test_exc();
    stall = 1'b1; br_req = 1'b1; br_target = 32'h3800;
    step();
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3020; br_target = 32'h3900;
    step();
    checks++;
    if (pc !== 32'h4180 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL exc: got pc=%h pend=%b want 00004180/0", pc, redir_pend);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h4184) begin
      errors++; $display("FAIL exc_seq: got %h want 00004184", pc);
    end
  endtask

  task automatic test_eret();
    stall = 1'b1; br_req = 1'b1; br_target = 32'h3900;
    step();
    br_req = 1'b0; eret_req = 1'b1; epc = 32'h3020;
    step();
    checks++;
    if (pc !== 32'h3020 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL eret: got pc=%h pend=%b want 00003020/0", pc, redir_pend);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h3024) begin
      errors++; $display("FAIL eret_seq: got %h want 00003024", pc);
    end
  endtask

  task automatic test_wrap();
    br_req = 1'b1; br_target = 32'hffff_fffc;
    step();
    br_req = 1'b0;
    step();
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap: got %h want 00000000", pc);
    end
  endtask

  task automatic test_addr_chk();
    logic [31:0] tgt [4];
    logic        exp [4];
    tgt[0] = 32'h3002; tgt[1] = 32'h7000; tgt[2] = 32'h6ffc; tgt[3] = 32'h2ffc;
`ifdef FETCH_PC_ADDR_CHK_EN
    exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b0; exp[3] = 1'b1;
`else
    exp[0] = 1'b0; exp[1] = 1'b0; exp[2] = 1'b0; exp[3] = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      br_req = 1'b1; br_target = tgt[i];
      step();
      checks++;
      if (pc !== tgt[i] || fetch_exc !== exp[i]) begin
        errors++; $display("FAIL addr_chk%0d: got pc=%h exc=%b want %h/%b", i, pc, fetch_exc,
                           tgt[i], exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_pending();
    stall = 1'b1; br_req = 1'b1; br_target = 32'h3a00;
    step();
    checks++;
    if (redir_pend !== 1'b1) begin
      errors++; $display("FAIL rstpend_setup: got pend=%b want 1", redir_pend);
    end
    rst = 1'b1;
    step();
    checks++;
    if (pc !== 32'h3000 || redir_pend !== 1'b0) begin
      errors++; $display("FAIL rstpend: got pc=%h pend=%b want 00003000/0", pc, redir_pend);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h3004) begin
      errors++; $display("FAIL rstpend_seq: got %h want 00003004", pc);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1; epc = 32'h0; br_target = 32'h0;
    test_reset();
    test_pending();
    test_overwrite();
    test_exc();
    test_eret();
    test_wrap();
    test_addr_chk();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
